// File: rtl/regfile_mp.sv
// Multi-port register file with SP, PC and masked CCR with one-level interrupt shadow.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NREG     = 8,
  parameter int unsigned AW       = 4,
  parameter int unsigned CCR_W    = 4,
  parameter logic [31:0] SP_RESET = 32'd2047,
  parameter logic [31:0] SP_MIN   = 32'd0,
  parameter logic [31:0] SP_MAX   = 32'd2047,
  parameter logic [31:0] PC_RESET = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2,
  input  logic             wr_en1,
  input  logic [AW-1:0]    wr_addr1,
  input  logic [WIDTH-1:0] wr_data1,
  input  logic             wr_en2,
  input  logic [AW-1:0]    wr_addr2,
  input  logic [WIDTH-1:0] wr_data2,
  input  logic [1:0]       sp_op,
  input  logic [31:0]      sp_load_data,
  output logic [31:0]      sp,
  output logic             sp_fault,
  input  logic [1:0]       pc_op,
  input  logic [31:0]      pc_load_data,
  output logic [31:0]      pc,
  input  logic [CCR_W-1:0] ccr_wr_mask,
  input  logic [CCR_W-1:0] ccr_wr_data,
  input  logic             ccr_save,
  input  logic             ccr_restore,
  output logic [CCR_W-1:0] ccr
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW:0] NregW = (AW + 1)'(NREG);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [31:0]      sp_q, sp_d, pc_q, pc_d;
  logic             sp_fault_q, sp_fault_d;
  logic [CCR_W-1:0] ccr_q, ccr_d, shadow_q, shadow_d;
  logic             rd1_ok, rd2_ok, wr1_ok, wr2_ok;

  assign rd1_ok = {1'b0, rd_addr1} < NregW;
  assign rd2_ok = {1'b0, rd_addr2} < NregW;
  assign wr1_ok = wr_en1 && ({1'b0, wr_addr1} < NregW);
  assign wr2_ok = wr_en2 && ({1'b0, wr_addr2} < NregW);

  always_comb begin
    rd_data1 = rd1_ok ? regs_q[rd_addr1[IW-1:0]] : '0;
    rd_data2 = rd2_ok ? regs_q[rd_addr2[IW-1:0]] : '0;
`ifdef REGFILE_BYPASS_EN
    // Port 2 is applied last so it wins when both write ports match.
    if (wr1_ok && (wr_addr1 == rd_addr1)) rd_data1 = wr_data1;
    if (wr2_ok && (wr_addr2 == rd_addr1)) rd_data1 = wr_data2;
    if (wr1_ok && (wr_addr1 == rd_addr2)) rd_data2 = wr_data1;
    if (wr2_ok && (wr_addr2 == rd_addr2)) rd_data2 = wr_data2;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (wr1_ok) regs_q[wr_addr1[IW-1:0]] <= wr_data1;
      if (wr2_ok) regs_q[wr_addr2[IW-1:0]] <= wr_data2;
    end
  end

  always_comb begin
    sp_d       = sp_q;
    sp_fault_d = sp_fault_q;
    unique case (sp_op)
      2'b01: begin
        if (sp_q == SP_MIN) sp_fault_d = 1'b1;
        else                sp_d       = sp_q - 32'd1;
      end
      2'b10: begin
        if (sp_q == SP_MAX) sp_fault_d = 1'b1;
        else                sp_d       = sp_q + 32'd1;
      end
      2'b11: begin
        sp_d       = sp_load_data;
        sp_fault_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (pc_op)
      2'b01:   pc_d = pc_q + 32'd1;
      2'b10:   pc_d = pc_load_data;
      2'b11:   pc_d = pc_q + 32'd2;
      default: ;
    endcase
  end

  always_comb begin
    ccr_d    = (ccr_q & ~ccr_wr_mask) | (ccr_wr_data & ccr_wr_mask);
    shadow_d = shadow_q;
    if (ccr_restore) ccr_d    = shadow_q;
    if (ccr_save)    shadow_d = ccr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q       <= SP_RESET;
      sp_fault_q <= 1'b0;
      pc_q       <= PC_RESET;
      ccr_q      <= '0;
      shadow_q   <= '0;
    end else begin
      sp_q       <= sp_d;
      sp_fault_q <= sp_fault_d;
      pc_q       <= pc_d;
      ccr_q      <= ccr_d;
      shadow_q   <= shadow_d;
    end
  end

  assign sp       = sp_q;
  assign sp_fault = sp_fault_q;
  assign pc       = pc_q;
  assign ccr      = ccr_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: per-cycle model comparison plus directed literal checks.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr1, wr_addr2;
  logic [15:0] rd_data1, rd_data2, wr_data1, wr_data2;
  logic        wr_en1, wr_en2;
  logic [1:0]  sp_op, pc_op;
  logic [31:0] sp_load_data, sp, pc_load_data, pc;
  logic        sp_fault;
  logic [3:0]  ccr_wr_mask, ccr_wr_data, ccr;
  logic        ccr_save, ccr_restore;

  int errs   = 0;
  int checks = 0;

  regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr1    (rd_addr1),
    .rd_data1    (rd_data1),
    .rd_addr2    (rd_addr2),
    .rd_data2    (rd_data2),
    .wr_en1      (wr_en1),
    .wr_addr1    (wr_addr1),
    .wr_data1    (wr_data1),
    .wr_en2      (wr_en2),
    .wr_addr2    (wr_addr2),
    .wr_data2    (wr_data2),
    .sp_op       (sp_op),
    .sp_load_data(sp_load_data),
    .sp          (sp),
    .sp_fault    (sp_fault),
    .pc_op       (pc_op),
    .pc_load_data(pc_load_data),
    .pc          (pc),
    .ccr_wr_mask (ccr_wr_mask),
    .ccr_wr_data (ccr_wr_data),
    .ccr_save    (ccr_save),
    .ccr_restore (ccr_restore),
    .ccr         (ccr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the architectural state.
  logic [15:0] m_reg [16];
  logic [31:0] m_sp, m_pc;
  logic        m_fault;
  logic [3:0]  m_ccr, m_sh;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= 16'h0;
      m_sp    <= 32'd2047;
      m_pc    <= 32'd0;
      m_fault <= 1'b0;
      m_ccr   <= 4'h0;
      m_sh    <= 4'h0;
    end else begin
      if (wr_en1 && int'(wr_addr1) < 8) m_reg[wr_addr1] <= wr_data1;
      if (wr_en2 && int'(wr_addr2) < 8) m_reg[wr_addr2] <= wr_data2;
      case (sp_op)
        2'd1: if (m_sp == 32'd0) m_fault <= 1'b1; else m_sp <= m_sp - 1;
        2'd2: if (m_sp == 32'd2047) m_fault <= 1'b1; else m_sp <= m_sp + 1;
        2'd3: begin m_sp <= sp_load_data; m_fault <= 1'b0; end
        default: ;
      endcase
      case (pc_op)
        2'd1: m_pc <= m_pc + 1;
        2'd2: m_pc <= pc_load_data;
        2'd3: m_pc <= m_pc + 2;
        default: ;
      endcase
      if (ccr_restore) m_ccr <= m_sh;
      else             m_ccr <= (m_ccr & ~ccr_wr_mask) | (ccr_wr_data & ccr_wr_mask);
      if (ccr_save) m_sh <= m_ccr;
    end
  end

  function automatic logic [15:0] exp_rd(input logic [3:0] a);
    logic [15:0] v;
    v = (int'(a) < 8) ? m_reg[a] : 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en1 && int'(wr_addr1) < 8 && wr_addr1 == a) v = wr_data1;
    if (wr_en2 && int'(wr_addr2) < 8 && wr_addr2 == a) v = wr_data2;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rd_data1", 32'(rd_data1), 32'(exp_rd(rd_addr1)));
      chk("rd_data2", 32'(rd_data2), 32'(exp_rd(rd_addr2)));
      chk("sp", sp, m_sp);
      chk("sp_fault", 32'(sp_fault), 32'(m_fault));
      chk("pc", pc, m_pc);
      chk("ccr", 32'(ccr), 32'(m_ccr));
    end
  end

  task automatic idle();
    rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    wr_en1 = 1'b0; wr_addr1 = 4'd0; wr_data1 = 16'h0;
    wr_en2 = 1'b0; wr_addr2 = 4'd0; wr_data2 = 16'h0;
    sp_op = 2'd0; sp_load_data = 32'd0;
    pc_op = 2'd0; pc_load_data = 32'd0;
    ccr_wr_mask = 4'h0; ccr_wr_data = 4'h0; ccr_save = 1'b0; ccr_restore = 1'b0;
  endtask

  task automatic randomize_inputs();
    rd_addr1 = 4'($urandom_range(0, 15)); rd_addr2 = 4'($urandom_range(0, 15));
    wr_en1 = 1'($urandom); wr_addr1 = 4'($urandom_range(0, 9)); wr_data1 = 16'($urandom);
    wr_en2 = 1'($urandom); wr_addr2 = 4'($urandom_range(0, 9)); wr_data2 = 16'($urandom);
    sp_op = 2'($urandom); sp_load_data = 32'($urandom_range(0, 2047));
    pc_op = 2'($urandom); pc_load_data = $urandom;
    ccr_wr_mask = 4'($urandom); ccr_wr_data = 4'($urandom);
    ccr_save = 1'($urandom); ccr_restore = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1 rst = 1'b0;
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick();
    end
    idle();
    #1;
    chk("reset sp", sp, 32'd2047);
    chk("reset pc", pc, 32'd0);
    chk("reset ccr", 32'(ccr), 32'd0);
    chk("reset sp_fault", 32'(sp_fault), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = 4'(a); rd_addr2 = 4'(7 - a);
      #1;
      chk("reset rd1", 32'(rd_data1), 32'd0);
      chk("reset rd2", 32'(rd_data2), 32'd0);
    end
    idle();
    rst = 1'b1;

    // Write-port conflict plus out-of-range write.
    tick();
    wr_en1 = 1'b1; wr_addr1 = 4'd3; wr_data1 = 16'h1111;
    wr_en2 = 1'b1; wr_addr2 = 4'd3; wr_data2 = 16'h2222;
    rd_addr1 = 4'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass rd1 same cycle", 32'(rd_data1), 32'h2222);
`else
    chk("no-bypass rd1 same cycle", 32'(rd_data1), 32'h0);
`endif
    tick();
    idle();
    wr_en1 = 1'b1; wr_addr1 = 4'd9; wr_data1 = 16'hDEAD;
    wr_en2 = 1'b1; wr_addr2 = 4'd6; wr_data2 = 16'h6666;
    rd_addr1 = 4'd3; rd_addr2 = 4'd9;
    #1;
    chk("reg3 conflict", 32'(rd_data1), 32'h2222);
    chk("rd addr 9", 32'(rd_data2), 32'h0);
    tick();
    idle();
    rd_addr1 = 4'd6; rd_addr2 = 4'd1;
    #1;
    chk("reg6", 32'(rd_data1), 32'h6666);
    chk("reg1 untouched", 32'(rd_data2), 32'h0);

    // SP limits.
    sp_op = 2'd2;
    tick();
    chk("pop at max sp", sp, 32'd2047);
    chk("pop at max fault", 32'(sp_fault), 32'd1);
    sp_op = 2'd1;
    tick();
    chk("push sp", sp, 32'd2046);
    chk("push fault sticky", 32'(sp_fault), 32'd1);
    sp_op = 2'd3; sp_load_data = 32'd100;
    tick();
    chk("load sp", sp, 32'd100);
    chk("load clears fault", 32'(sp_fault), 32'd0);
    sp_op = 2'd3; sp_load_data = 32'd0;
    tick();
    sp_op = 2'd1;
    tick();
    chk("push at min sp", sp, 32'd0);
    chk("push at min fault", 32'(sp_fault), 32'd1);

    // PC wrap, step and stall.
    idle();
    pc_op = 2'd2; pc_load_data = 32'hFFFF_FFFF;
    tick();
    chk("pc load", pc, 32'hFFFF_FFFF);
    pc_op = 2'd1;
    tick();
    chk("pc wrap", pc, 32'd0);
    pc_op = 2'd3;
    tick();
    chk("pc +2", pc, 32'd2);
    pc_op = 2'd0;
    for (int i = 0; i < 3; i++) tick();
    chk("pc stall", pc, 32'd2);

    // CCR masked writes, shadow save/restore and swap.
    idle();
    ccr_wr_mask = 4'hF; ccr_wr_data = 4'b1000;
    tick();
    ccr_wr_mask = 4'h0; ccr_save = 1'b1;
    tick();
    ccr_save = 1'b0; ccr_wr_mask = 4'hF; ccr_wr_data = 4'b0101;
    tick();
    chk("ccr full write", 32'(ccr), 32'b0101);
    ccr_wr_mask = 4'b0011; ccr_wr_data = 4'b0010;
    tick();
    chk("ccr masked", 32'(ccr), 32'b0110);
    ccr_wr_mask = 4'hF; ccr_wr_data = 4'b1111; ccr_save = 1'b1; ccr_restore = 1'b1;
    tick();
    chk("ccr swap", 32'(ccr), 32'b1000);
    ccr_wr_mask = 4'h0; ccr_save = 1'b0; ccr_restore = 1'b1;
    tick();
    chk("shadow after swap", 32'(ccr), 32'b0110);

    // Random traffic checked against the model every cycle.
    for (int i = 0; i < 60; i++) begin
      randomize_inputs();
      tick();
    end

    // Asynchronous reset in mid-operation discards the in-flight write.
    idle();
    pc_op = 2'd2; pc_load_data = 32'h1234;
    sp_op = 2'd3; sp_load_data = 32'd500;
    ccr_wr_mask = 4'hF; ccr_wr_data = 4'hA;
    tick();
    wr_en1 = 1'b1; wr_addr1 = 4'd5; wr_data1 = 16'hABCD;
    sp_op = 2'd1; pc_op = 2'd1;
    #1 rst = 1'b0;
    #1;
    chk("async rst sp", sp, 32'd2047);
    chk("async rst pc", pc, 32'd0);
    chk("async rst ccr", 32'(ccr), 32'd0);
    tick();
    idle();
    rst = 1'b1;
    rd_addr1 = 4'd5;
    #1;
    chk("write lost in reset", 32'(rd_data1), 32'h0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
